// File: rtl/wb_increment_driver_pkg.sv
// Shared definitions for the Wishbone increment driver.
// Register map, control bits, FSM states and completion signature.
package wb_increment_driver_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PERIOD_OFF = 4'h4;
  localparam logic [3:0] STATUS_OFF = 4'h8;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam logic [3:0] CHECK_SIG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/increment_step_timer.sv
// Hold-period timer for the increment driver.
// Pulses expire when the count reaches P-1, P = max(period, 1).
module increment_step_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] period,
  output logic        expire
);

  logic [15:0] timer_q;
  logic [15:0] last;

  // >= lets a shortened period fire on the very next cycle
  assign last   = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign expire = en && (timer_q >= last);

  // Free-running hold counter, wraps on expire
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      timer_q <= 16'd0;
    end else if (en) begin
      timer_q <= expire ? 16'd0 : timer_q + 16'd1;
    end
  end

endmodule

// File: rtl/wb_increment_driver.sv
// Wishbone slave driving a 0..F increment sequence on mprj_io.
// Raises the completion signature once the sequence finishes.
module wb_increment_driver
  import wb_increment_driver_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [15:0] PERIOD_RST = 16'd100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  check_q, check_d;
  logic [15:0] period_q;
  logic [31:0] rdata;
  logic        hit, req, wr, rd;
  logic [3:0]  off;
  logic        start_req, abort_req;
  logic        tmr_clr, tmr_en, expire;
  logic        unused_bits;

  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && hit;
  assign wr  = req && wbs_we_i;
  assign rd  = req && !wbs_we_i;
  assign off = wbs_adr_i[3:0];

  assign start_req = wr && (off == CTRL_OFF) && wbs_sel_i[0]
                     && wbs_dat_i[CTRL_START];
  assign abort_req = wr && (off == CTRL_OFF) && wbs_sel_i[0]
                     && wbs_dat_i[CTRL_ABORT];

  assign tmr_en = (state_q == ST_COUNT);

  increment_step_timer u_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .period (period_q),
    .expire (expire)
  );

  // PERIOD register with per-lane writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      period_q <= PERIOD_RST;
    end else if (wr && (off == PERIOD_OFF)) begin
      if (wbs_sel_i[0]) period_q[7:0]  <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) period_q[15:8] <= wbs_dat_i[15:8];
    end
  end

  // Read mux for the register window
  always_comb begin
    rdata = 32'd0;
    case (off)
      PERIOD_OFF: rdata = {16'd0, period_q};
      STATUS_OFF: rdata = {20'd0, check_q, count_q, 2'b00,
                           state_q == ST_DONE,
                           state_q == ST_COUNT};
      default:    rdata = 32'd0;
    endcase
  end

  // One-cycle ack; read data only alongside ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : 32'd0;
    end
  end

  // Sequence FSM state and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      check_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      check_q <= check_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    check_d = check_q;
    tmr_clr = 1'b0;
    if (abort_req) begin
      state_d = ST_IDLE;
      count_d = 4'd0;
      check_d = 4'd0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            state_d = ST_COUNT;
            count_d = 4'd0;
            check_d = 4'd0;
            tmr_clr = 1'b1;
          end
        end
        ST_COUNT: begin
          if (expire) begin
            if (count_q == 4'hF) begin
              state_d = ST_DONE;
              check_d = CHECK_SIG;
            end else begin
              count_d = count_q + 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign io_out = {6'd0, check_q, 24'd0, count_q};
  assign io_oeb = ~{6'd0, 4'hF, 24'd0, 4'hF};

endmodule

// File: tb/tb_wb_increment_driver.sv
// Directed bench for wb_increment_driver.
// Each task drives one scenario and checks inline.
module tb_wb_increment_driver;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [37:0] OEB_EXP = {6'h3F, 4'h0, 24'hFF_FFFF, 4'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_increment_driver dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat_o),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  function automatic logic [37:0] exp_io(input logic [3:0] c,
                                         input logic [3:0] k);
    return {6'd0, k, 24'd0, c};
  endfunction

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic acked, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    acked = ack;
    rd = rdat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic a;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (io_out !== 38'd0) begin
      bad++; $display("FAIL reset_io_out got %h want 0", io_out);
    end
    total++;
    if (io_oeb !== OEB_EXP) begin
      bad++; $display("FAIL reset_io_oeb got %h want %h", io_oeb, OEB_EXP);
    end
    total++;
    if (ack !== 1'b0 || rdat_o !== 32'd0) begin
      bad++; $display("FAIL reset_wb got ack=%b dat=%h want 0/0", ack, rdat_o);
    end
    rst = 1'b0;
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, a, d);
    total++;
    if (a !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL reset_status got ack=%b %h want 1/0", a, d);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (a !== 1'b1 || d !== 32'd100) begin
      bad++; $display("FAIL reset_period got ack=%b %0d want 1/100", a, d);
    end
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, a, d);
    total++;
    if (a !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL ctrl_read got ack=%b %h want 1/0", a, d);
    end
  endtask

  task automatic test_count_p4;
    logic a;
    logic [31:0] d;
    logic [37:0] e;
    int errs;
    wb_xfer(1'b1, BASE + 32'h4, 32'd4, 4'hF, a, d);
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    total++;
    if (a !== 1'b1) begin
      bad++; $display("FAIL p4_start_ack got %b want 1", a);
    end
    errs = 0;
    for (int i = 0; i <= 64; i++) begin
      e = (i < 64) ? exp_io(4'(i / 4), 4'h0) : exp_io(4'hF, 4'hA);
      total++;
      if (io_out !== e) begin
        bad++; errs++;
        if (errs < 5)
          $display("FAIL p4_seq cyc=%0d got %h want %h", i, io_out, e);
      end
      if (i < 64) @(negedge clk);
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'hAF2) begin
      bad++; $display("FAIL p4_status got %h want af2", d);
    end
  endtask

  task automatic test_period_zero;
    logic a;
    logic [31:0] d;
    logic [37:0] e;
    wb_xfer(1'b1, BASE + 32'h4, 32'd0, 4'hF, a, d);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'd0) begin
      bad++; $display("FAIL p0_readback got %h want 0", d);
    end
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    for (int i = 0; i <= 16; i++) begin
      e = (i < 16) ? exp_io(4'(i), 4'h0) : exp_io(4'hF, 4'hA);
      total++;
      if (io_out !== e) begin
        bad++; $display("FAIL p0_seq cyc=%0d got %h want %h", i, io_out, e);
      end
      if (i < 16) @(negedge clk);
    end
  endtask

  task automatic test_abort;
    logic a;
    logic [31:0] d;
    int n;
    wb_xfer(1'b1, BASE + 32'h4, 32'd8, 4'hF, a, d);
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    n = 0;
    while (io_out[3:0] !== 4'd5 && n < 200) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL abort_wait5 got %h want count 5", io_out);
    end
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    total++;
    if (io_out !== exp_io(4'd5, 4'h0)) begin
      bad++; $display("FAIL start_in_count got %h want %h",
                      io_out, exp_io(4'd5, 4'h0));
    end
    wb_xfer(1'b1, BASE, 32'd2, 4'hF, a, d);
    total++;
    if (io_out !== 38'd0) begin
      bad++; $display("FAIL abort_io got %h want 0", io_out);
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'd0) begin
      bad++; $display("FAIL abort_status got %h want 0", d);
    end
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    repeat (127) @(negedge clk);
    total++;
    if (io_out !== exp_io(4'hF, 4'h0)) begin
      bad++; $display("FAIL restart_pre got %h want %h",
                      io_out, exp_io(4'hF, 4'h0));
    end
    @(negedge clk);
    total++;
    if (io_out !== exp_io(4'hF, 4'hA)) begin
      bad++; $display("FAIL restart_done got %h want %h",
                      io_out, exp_io(4'hF, 4'hA));
    end
    wb_xfer(1'b1, BASE, 32'd3, 4'hF, a, d);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, a, d);
    total++;
    if (io_out !== 38'd0 || d !== 32'd0) begin
      bad++; $display("FAIL abort_wins got io=%h st=%h want 0/0", io_out, d);
    end
  endtask

  task automatic test_reset_mid;
    logic a;
    logic [31:0] d;
    int n;
    wb_xfer(1'b1, BASE + 32'h4, 32'd2, 4'hF, a, d);
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    n = 0;
    while (io_out[3:0] !== 4'd9 && n < 200) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL rst_wait9 got %h want count 9", io_out);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (io_out !== 38'd0 || ack !== 1'b0 || rdat_o !== 32'd0) begin
      bad++; $display("FAIL rst_mid got io=%h ack=%b dat=%h want 0/0/0",
                      io_out, ack, rdat_o);
    end
    @(negedge clk);
    rst = 1'b0;
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'd100) begin
      bad++; $display("FAIL rst_period got %0d want 100", d);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'd1, 4'hF, a, d);
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, a, d);
    repeat (3) @(negedge clk);
    total++;
    if (io_out !== exp_io(4'd3, 4'h0)) begin
      bad++; $display("FAIL rst_restart got %h want %h",
                      io_out, exp_io(4'd3, 4'h0));
    end
    wb_xfer(1'b1, BASE, 32'd2, 4'hF, a, d);
  endtask

  task automatic test_sel_and_window;
    logic a;
    logic [31:0] d;
    wb_xfer(1'b1, BASE + 32'h4, 32'h1234, 4'b0001, a, d);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'h0034) begin
      bad++; $display("FAIL sel_lane0 got %h want 0034", d);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'hFFFF_AB00, 4'b0010, a, d);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'hAB34) begin
      bad++; $display("FAIL sel_lane1 got %h want ab34", d);
    end
    wb_xfer(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, a, d);
    total++;
    if (a !== 1'b1) begin
      bad++; $display("FAIL off_c_write_ack got %b want 1", a);
    end
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, a, d);
    total++;
    if (a !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL off_c_read got ack=%b %h want 1/0", a, d);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'hAB34 || io_out !== 38'd0) begin
      bad++; $display("FAIL off_c_nochange got %h io=%h want ab34/0",
                      d, io_out);
    end
    wb_xfer(1'b1, BASE + 32'h10, 32'd1, 4'hF, a, d);
    total++;
    if (a !== 1'b0) begin
      bad++; $display("FAIL outside_write_ack got %b want 0", a);
    end
    wb_xfer(1'b0, BASE + 32'h14, 32'd0, 4'hF, a, d);
    total++;
    if (a !== 1'b0 || d !== 32'd0) begin
      bad++; $display("FAIL outside_read got ack=%b %h want 0/0", a, d);
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, a, d);
    total++;
    if (d !== 32'd0) begin
      bad++; $display("FAIL outside_nostart got %h want 0", d);
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    int dbl;
    logic prev;
    acks = 0; dbl = 0; prev = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
      if (ack === 1'b1 && prev) dbl++;
      prev = (ack === 1'b1);
    end
    cyc = 1'b0; stb = 1'b0;
    total++;
    if (acks !== 3 || dbl !== 0) begin
      bad++; $display("FAIL back_to_back got acks=%0d dbl=%0d want 3/0",
                      acks, dbl);
    end
  endtask

  initial begin
    test_reset();
    test_count_p4();
    test_period_zero();
    test_abort();
    test_reset_mid();
    test_sel_and_window();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_increment_driver.md
# wb_increment_driver

Wishbone-slave user-project block that produces the 4-bit increment sequence 0x0 through 0xF on `mprj_io[3:0]`, then raises the completion signature 0xA on `mprj_io[31:28]`. Management-core firmware programs a hold period and starts or aborts a run over the Caravel Wishbone bus. The block sits in `user_project_wrapper` and is the hardware counterpart of the chip-level increment-check testbench.

## Interface
- `BASE_ADDR`, 32'h3000_0000: Wishbone base; decode on `wbs_adr_i[31:4]`.
- `PERIOD_RST`, 16'd100: reset value of the PERIOD register.
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: reset, synchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone classic controls.
- `wbs_sel_i`  in  4: byte-lane enables.
- `wbs_adr_i`  in  32: byte address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: one-cycle acknowledge.
- `wbs_dat_o`  out  32: read data; 0 whenever `wbs_ack_o`=0.
- `io_out`  out  38: `[3:0]` = count, `[31:28]` = checkbits, all other bits 0.
- `io_oeb`  out  38: 0 on bits `[3:0]` and `[31:28]`, 1 on all other bits.

## Operation
- Registers, at offsets from `BASE_ADDR`:
  - 0x0 CTRL (write-only, reads 0): bit0 start, bit1 abort. Both are self-clearing pulses.
  - 0x4 PERIOD (read/write): `[15:0]` hold cycles per count value. Upper bits read 0.
  - 0x8 STATUS (read-only): bit0 busy, bit1 done, `[7:4]` count, `[11:8]` checkbits.
  - Other offsets inside the 16-byte window: acked, write ignored, read 0. Addresses outside the window are not acked.
- Writes apply only to byte lanes with `wbs_sel_i` set. CTRL bits live in lane 0.
- Effective period `P` = max(PERIOD, 1).
- FSM with states IDLE, COUNT, DONE:
  - IDLE→COUNT on start: count←0, checkbits←0, timer←0.
  - COUNT: timer increments each cycle. When timer==P-1: timer←0.
    - If count≠0xF: count←count+1.
    - If count==0xF: →DONE, checkbits←0xA, count holds 0xF.
  - DONE→COUNT on start, with the same initialisation as from IDLE.
  - Abort from any state: →IDLE, count←0, checkbits←0, timer←0.
  - Abort and start in the same write: abort wins.
  - Start while in COUNT is ignored.
- A PERIOD write during COUNT takes effect at the next timer compare. If timer ≥ new P-1, the compare fires on the next cycle.
- busy = (state==COUNT); done = (state==DONE).
- Reset values: state IDLE, count 0, checkbits 0, timer 0, PERIOD=`PERIOD_RST`, `wbs_ack_o`=0, `wbs_dat_o`=0, `io_out`=0. `io_oeb` is constant.

## Timing
- Request accepted on an edge where cyc&stb&!ack. Register and FSM effects apply at that same edge. `wbs_ack_o` (and `wbs_dat_o` on reads) is high for exactly the following cycle.
- Back-to-back requests: at most one ack every two cycles, because ack is never held across a second accepted request.
- Count value k (for k=0..14) is driven for exactly P cycles. 0xF is driven for P cycles before checkbits becomes 0xA. Start edge to checkbits=0xA is exactly 16·P cycles.
- `io_out` is registered: no combinational path from Wishbone inputs.
- Reset asserted mid-run returns every register to its reset value at the next edge. Any pending ack is dropped.

## Structure
- Package `wb_increment_driver_pkg` holds:
  - register offsets (`CTRL_OFF`, `PERIOD_OFF`, `STATUS_OFF`);
  - CTRL bit indices;
  - the FSM state enum;
  - `CHECK_SIG`=4'hA.
- One sub-module, `increment_step_timer`: 16-bit timer with a clear input and an expire pulse at P-1. The top block holds the Wishbone decode, registers and FSM.

## Test plan
- Reset → `io_out`=0; `io_oeb` bits `[3:0]`,`[31:28]`=0, all others 1; STATUS reads 0x0; PERIOD reads 100.
- PERIOD=4, start → count 0..F with each value held 4 cycles; checkbits=0xA at 64 cycles after the start edge; STATUS reads 0xAF2.
- PERIOD=0, start → behaves as P=1: count changes every cycle; done after 16 cycles.
- PERIOD=8, start, then at count=5 write start again (ignored), then abort → count 0, IDLE, STATUS 0x0. Restart completes normally.
- `wb_rst_i` pulsed at count=9 → next edge all outputs 0, PERIOD=100; a subsequent start works.
- Write PERIOD=0x1234 with `wbs_sel_i`=4'b0001 → reads 0x0034. Write to offset 0xC → acked, no state change. Access at `BASE_ADDR`+0x10 → no ack.
